// File: rtl/issue_scheduler_if.sv
// Dispatch, writeback, flush and per-pipeline issue bundle of the issue scheduler.
interface issue_scheduler_if #(
   parameter int unsigned OP_W      = 56,
   parameter int unsigned PR_ADDR_W = 5
);
   logic [OP_W-1:0]        disp_instr;
   logic [1:0]             disp_class;
   logic [3:0]             disp_src_mask;
   logic [1:0]             disp_dest_mask;
   logic                   disp_valid;
   logic                   disp_ready;
   logic [5*PR_ADDR_W-1:0] wb_addrs;
   logic [4:0]             wb_en;
   logic                   flush;
   logic [OP_W-1:0]        arith_instr;
   logic [OP_W-1:0]        mem_instr;
   logic [OP_W-1:0]        term_instr;
   logic                   arith_valid;
   logic                   mem_valid;
   logic                   term_valid;
   logic                   mem_ready;
   logic                   term_ready;

   modport master (
      output disp_instr, disp_class, disp_src_mask, disp_dest_mask, disp_valid,
      output wb_addrs, wb_en, flush, mem_ready, term_ready,
      input  disp_ready, arith_instr, mem_instr, term_instr,
      input  arith_valid, mem_valid, term_valid
   );

   modport slave (
      input  disp_instr, disp_class, disp_src_mask, disp_dest_mask, disp_valid,
      input  wb_addrs, wb_en, flush, mem_ready, term_ready,
      output disp_ready, arith_instr, mem_instr, term_instr,
      output arith_valid, mem_valid, term_valid
   );
endinterface

// File: rtl/issue_scheduler.sv
// Collapsing age-ordered issue queue with a physical-register ready scoreboard;
// issues one op per cycle each to the arith (out of order), mem and term (in order) pipes.
module issue_scheduler #(
   parameter int unsigned OP_W      = 56,
   parameter int unsigned PR_ADDR_W = 5,
   parameter int unsigned DEPTH     = 8
) (
   input logic             clk,
   input logic             rst,
   issue_scheduler_if.slave bus
);
   localparam int unsigned NPR      = 1 << PR_ADDR_W;
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W    = $clog2(DEPTH);
   localparam int unsigned NCAND    = DEPTH + 1;
   localparam int unsigned SEL_W    = $clog2(NCAND);
   localparam int unsigned SRC_LSB  = 8;
   localparam int unsigned DST_LSB  = 28;
   localparam int unsigned FDST_LSB = 33;
   localparam logic [1:0]  CLS_ARITH = 2'd0;
   localparam logic [1:0]  CLS_MEM   = 2'd1;
   localparam logic [1:0]  CLS_TERM  = 2'd2;
   localparam logic [1:0]  CLS_ILL   = 2'd3;

   logic [OP_W-1:0]  op_q    [DEPTH];
   logic [OP_W-1:0]  op_d    [DEPTH];
   logic [1:0]       cls_q   [DEPTH];
   logic [1:0]       cls_d   [DEPTH];
   logic [3:0]       smask_q [DEPTH];
   logic [3:0]       smask_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic [NPR-1:0]   ready_q, ready_d;
   logic [OP_W-1:0]  arith_instr_q, arith_instr_d, mem_instr_q, mem_instr_d;
   logic [OP_W-1:0]  term_instr_q, term_instr_d;
   logic             arith_valid_q, arith_valid_d, mem_valid_q, mem_valid_d;
   logic             term_valid_q, term_valid_d, disp_ready_q, disp_ready_d;

   logic [OP_W-1:0]  c_op    [NCAND];
   logic [1:0]       c_cls   [NCAND];
   logic [NCAND-1:0] c_vld, c_elig, rm;
   logic             accept, mem_ld_ok, term_ld_ok;
   logic             a_found, m_seen, m_found, t_seen, t_found;
   logic [SEL_W-1:0] a_sel, m_sel, t_sel;
   logic [CNT_W-1:0] wr;

   // Every real source operand reads ready in the registered scoreboard.
   function automatic logic src_ok(input logic [OP_W-1:0] op, input logic [3:0] sm,
                                   input logic [NPR-1:0] rdy);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (sm[k] && !rdy[op[SRC_LSB + k*PR_ADDR_W +: PR_ADDR_W]]) ok = 1'b0;
      end
      return ok;
   endfunction

   assign bus.disp_ready  = disp_ready_q;
   assign bus.arith_instr = arith_instr_q;
   assign bus.arith_valid = arith_valid_q;
   assign bus.mem_instr   = mem_instr_q;
   assign bus.mem_valid   = mem_valid_q;
   assign bus.term_instr  = term_instr_q;
   assign bus.term_valid  = term_valid_q;

   always_comb begin
      accept     = bus.disp_valid && disp_ready_q;
      mem_ld_ok  = !mem_valid_q || bus.mem_ready;
      term_ld_ok = !term_valid_q || bus.term_ready;
      a_found = 1'b0; m_seen = 1'b0; m_found = 1'b0; t_seen = 1'b0; t_found = 1'b0;
      a_sel = '0; m_sel = '0; t_sel = '0;
      rm = '0;
      wr = '0;

      // Queue entries first, then the incoming op as the youngest candidate.
      for (int i = 0; i < int'(DEPTH); i++) begin
         c_vld[i] = CNT_W'(i) < count_q;
         c_op[i]  = op_q[i];
         c_cls[i] = cls_q[i];
         c_elig[i] = src_ok(op_q[i], smask_q[i], ready_q);
      end
      c_vld[DEPTH]  = accept && (bus.disp_class != CLS_ILL);
      c_op[DEPTH]   = bus.disp_instr;
      c_cls[DEPTH]  = bus.disp_class;
      c_elig[DEPTH] = src_ok(bus.disp_instr, bus.disp_src_mask, ready_q);

      for (int i = 0; i < int'(NCAND); i++) begin
         if (c_vld[i]) begin
            if (c_cls[i] == CLS_ARITH && c_elig[i] && !a_found) begin
               a_found = 1'b1;
               a_sel   = SEL_W'(i);
            end
            if (c_cls[i] == CLS_MEM && !m_seen) begin
               m_seen = 1'b1;
               if (c_elig[i] && mem_ld_ok) begin
                  m_found = 1'b1;
                  m_sel   = SEL_W'(i);
               end
            end
            if (c_cls[i] == CLS_TERM && !t_seen) begin
               t_seen = 1'b1;
               if (c_elig[i] && term_ld_ok) begin
                  t_found = 1'b1;
                  t_sel   = SEL_W'(i);
               end
            end
         end
      end
      for (int i = 0; i < int'(NCAND); i++) begin
         rm[i] = (a_found && a_sel == SEL_W'(i)) || (m_found && m_sel == SEL_W'(i)) ||
                 (t_found && t_sel == SEL_W'(i));
      end

      // Collapse survivors toward entry 0, then append an unissued dispatch.
      for (int i = 0; i < int'(DEPTH); i++) begin
         op_d[i]    = op_q[i];
         cls_d[i]   = cls_q[i];
         smask_d[i] = smask_q[i];
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (c_vld[i] && !rm[i]) begin
            op_d[wr[IDX_W-1:0]]    = op_q[i];
            cls_d[wr[IDX_W-1:0]]   = cls_q[i];
            smask_d[wr[IDX_W-1:0]] = smask_q[i];
            wr = wr + CNT_W'(1);
         end
      end
      if (c_vld[DEPTH] && !rm[DEPTH]) begin
         op_d[wr[IDX_W-1:0]]    = bus.disp_instr;
         cls_d[wr[IDX_W-1:0]]   = bus.disp_class;
         smask_d[wr[IDX_W-1:0]] = bus.disp_src_mask;
         wr = wr + CNT_W'(1);
      end
      count_d      = wr;
      disp_ready_d = count_d < CNT_W'(DEPTH);

      arith_valid_d = a_found;
      arith_instr_d = a_found ? c_op[a_sel] : arith_instr_q;
      mem_valid_d   = m_found ? 1'b1 : (mem_valid_q && !bus.mem_ready);
      mem_instr_d   = m_found ? c_op[m_sel] : mem_instr_q;
      term_valid_d  = t_found ? 1'b1 : (term_valid_q && !bus.term_ready);
      term_instr_d  = t_found ? c_op[t_sel] : term_instr_q;

      // Writebacks set ready; a same-cycle dispatch clear wins.
      ready_d = ready_q;
      for (int l = 0; l < 5; l++) begin
         if (bus.wb_en[l]) ready_d[bus.wb_addrs[l*PR_ADDR_W +: PR_ADDR_W]] = 1'b1;
      end
      if (c_vld[DEPTH]) begin
         if (bus.disp_dest_mask[0]) ready_d[bus.disp_instr[DST_LSB +: PR_ADDR_W]] = 1'b0;
         if (bus.disp_dest_mask[1]) ready_d[bus.disp_instr[FDST_LSB +: PR_ADDR_W]] = 1'b0;
      end

      if (bus.flush) begin
         count_d       = '0;
         ready_d       = '1;
         disp_ready_d  = 1'b1;
         arith_valid_d = 1'b0;
         mem_valid_d   = 1'b0;
         term_valid_d  = 1'b0;
         arith_instr_d = '0;
         mem_instr_d   = '0;
         term_instr_d  = '0;
      end
      ready_d[0] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q       <= '0;
         ready_q       <= '1;
         disp_ready_q  <= 1'b1;
         arith_valid_q <= 1'b0;
         mem_valid_q   <= 1'b0;
         term_valid_q  <= 1'b0;
         arith_instr_q <= '0;
         mem_instr_q   <= '0;
         term_instr_q  <= '0;
      end else begin
         count_q       <= count_d;
         ready_q       <= ready_d;
         disp_ready_q  <= disp_ready_d;
         arith_valid_q <= arith_valid_d;
         mem_valid_q   <= mem_valid_d;
         term_valid_q  <= term_valid_d;
         arith_instr_q <= arith_instr_d;
         mem_instr_q   <= mem_instr_d;
         term_instr_q  <= term_instr_d;
      end
   end

   // Payload storage is qualified by count_q, so it needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         op_q[i]    <= op_d[i];
         cls_q[i]   <= cls_d[i];
         smask_q[i] <= smask_d[i];
      end
   end
endmodule
